// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mandel_pkg
// Description : Shared widths, dispatcher state encoding and pixel record
//               for the Mandelbrot pixel dispatcher slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mandel_pkg;

    localparam int WORD_LENGTH = 32;
    localparam int FRAC        = 28;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int DEPTH_W     = 10;
    localparam int ITER_W      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } disp_state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [DEPTH_W-1:0] depth;
    } pixel_t;

endpackage
`default_nettype wire

// File: rtl/mandel_pixel_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : mandel_eng_if / mandel_pix_if
// Description : Engine-array bus and outgoing valid/ready pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface mandel_eng_if #(
    parameter int N_ENG       = 4,
    parameter int WORD_LENGTH = 32
);
    import mandel_pkg::*;

    logic [N_ENG-1:0]                  eng_start;
    logic [N_ENG-1:0][X_W-1:0]         eng_x;
    logic [N_ENG-1:0][Y_W-1:0]         eng_y;
    logic [N_ENG-1:0][WORD_LENGTH-1:0] eng_re_c;
    logic [N_ENG-1:0][WORD_LENGTH-1:0] eng_im_c;
    logic [ITER_W-1:0]                 eng_max_iter;
    logic [N_ENG-1:0]                  eng_done;
    logic [N_ENG-1:0][DEPTH_W-1:0]     eng_depth;

    modport master (
        output eng_start, eng_x, eng_y, eng_re_c, eng_im_c, eng_max_iter,
        input  eng_done, eng_depth
    );
    modport slave (
        input  eng_start, eng_x, eng_y, eng_re_c, eng_im_c, eng_max_iter,
        output eng_done, eng_depth
    );
endinterface

interface mandel_pix_if;
    import mandel_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [DEPTH_W-1:0] out_depth;
    logic [X_W-1:0]     out_x;
    logic [Y_W-1:0]     out_y;
    logic               out_sof;
    logic               out_eol;

    modport master (
        output out_valid, out_depth, out_x, out_y, out_sof, out_eol,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_depth, out_x, out_y, out_sof, out_eol,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mandel_coord_stepper.sv
`default_nettype none
// ============================================================================
// Module      : mandel_coord_stepper
// Description : Raster x/y counters with re/im accumulators; outputs show the
//               position about to be issued (load bypasses to pixel (0,0)).
// Revision    : 1.0 - initial release
// ============================================================================
module mandel_coord_stepper #(
    parameter int WORD_LENGTH = 32,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          advance,
    input  logic signed [WORD_LENGTH-1:0] re_left,
    input  logic signed [WORD_LENGTH-1:0] im_top,
    input  logic signed [WORD_LENGTH-1:0] step,
    output logic        [9:0]             x,
    output logic        [8:0]             y,
    output logic signed [WORD_LENGTH-1:0] cur_re,
    output logic signed [WORD_LENGTH-1:0] cur_im,
    output logic                          last_pixel,
    output logic                          eol
);
    import mandel_pkg::*;

    logic        [X_W-1:0]         r_x;
    logic        [Y_W-1:0]         r_y;
    logic signed [WORD_LENGTH-1:0] r_re;
    logic signed [WORD_LENGTH-1:0] r_im;
    logic signed [WORD_LENGTH-1:0] r_left;
    logic signed [WORD_LENGTH-1:0] r_step;
    logic signed [WORD_LENGTH-1:0] w_left;
    logic signed [WORD_LENGTH-1:0] w_step;

    // The frame-start cycle issues pixel (0,0) straight from the config inputs.
    always_comb begin
        w_left     = load ? re_left : r_left;
        w_step     = load ? step    : r_step;
        x          = load ? '0      : r_x;
        y          = load ? '0      : r_y;
        cur_re     = load ? re_left : r_re;
        cur_im     = load ? im_top  : r_im;
        eol        = (x == X_W'(SCREEN_W - 1));
        last_pixel = eol && (y == Y_W'(SCREEN_H - 1));
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_re   <= '0;
            r_im   <= '0;
            r_left <= '0;
            r_step <= '0;
        end else begin
            if (load) begin
                r_left <= re_left;
                r_step <= step;
            end
            if (advance) begin
                if (eol) begin
                    r_x  <= '0;
                    r_y  <= y + Y_W'(1);
                    r_re <= w_left;
                    r_im <= cur_im - w_step;
                end else begin
                    r_x  <= x + X_W'(1);
                    r_y  <= y;
                    r_re <= cur_re + w_step;
                    r_im <= cur_im;
                end
            end else if (load) begin
                r_x  <= x;
                r_y  <= y;
                r_re <= cur_re;
                r_im <= cur_im;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mandel_pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : mandel_pixel_dispatcher
// Description : Round-robin pixel issue to N_ENG depth engines, in-order
//               collection onto a valid/ready pixel stream.
//               Optional MANDEL_FRAME_STATS_EN adds per-frame statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module mandel_pixel_dispatcher #(
    parameter int N_ENG       = 4,
    parameter int WORD_LENGTH = mandel_pkg::WORD_LENGTH,
    parameter int SCREEN_W    = mandel_pkg::SCREEN_W,
    parameter int SCREEN_H    = mandel_pkg::SCREEN_H
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic signed [WORD_LENGTH-1:0] cfg_re_left,
    input  logic signed [WORD_LENGTH-1:0] cfg_im_top,
    input  logic signed [WORD_LENGTH-1:0] cfg_step,
    input  logic        [9:0]             cfg_max_iter,
    output logic                          busy,
    output logic                          frame_done,
`ifdef MANDEL_FRAME_STATS_EN
    output logic        [31:0]            stat_cycles,
    output logic        [31:0]            stat_iter_sum,
`endif
    mandel_eng_if.master                  eng,
    mandel_pix_if.master                  pix
);
    import mandel_pkg::*;

    localparam int PTR_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;

    disp_state_t                        r_state;
    disp_state_t                        w_state_nxt;
    logic [PTR_W-1:0]                   r_ip;
    logic [PTR_W-1:0]                   r_cp;
    logic [N_ENG-1:0]                   r_eng_busy;
    logic [N_ENG-1:0]                   r_eng_start;
    logic [N_ENG-1:0]                   r_eng_eol;
    logic [N_ENG-1:0][X_W-1:0]          r_eng_x;
    logic [N_ENG-1:0][Y_W-1:0]          r_eng_y;
    logic [N_ENG-1:0][WORD_LENGTH-1:0]  r_eng_re;
    logic [N_ENG-1:0][WORD_LENGTH-1:0]  r_eng_im;
    logic [ITER_W-1:0]                  r_max_iter;
    pixel_t                             r_out;
    logic                               r_out_valid;
    logic                               r_out_sof;
    logic                               r_out_eol;
    logic                               r_frame_done;

    logic                               w_accept;
    logic                               w_issue;
    logic                               w_collect;
    logic                               w_last_hs;
    logic [X_W-1:0]                     w_x;
    logic [Y_W-1:0]                     w_y;
    logic signed [WORD_LENGTH-1:0]      w_re;
    logic signed [WORD_LENGTH-1:0]      w_im;
    logic                               w_last_pixel;
    logic                               w_eol;

    mandel_coord_stepper #(
        .WORD_LENGTH (WORD_LENGTH),
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H)
    ) u_stepper (
        .sysclk     (sysclk),
        .reset      (reset),
        .load       (w_accept),
        .advance    (w_issue),
        .re_left    (cfg_re_left),
        .im_top     (cfg_im_top),
        .step       (cfg_step),
        .x          (w_x),
        .y          (w_y),
        .cur_re     (w_re),
        .cur_im     (w_im),
        .last_pixel (w_last_pixel),
        .eol        (w_eol)
    );

    assign w_accept  = (r_state == IDLE) && frame_start;
    assign w_issue   = ((r_state == RUN) || w_accept) && !r_eng_busy[r_ip];
    // eng_done is still the previous result while a fresh start is in flight.
    assign w_collect = r_eng_busy[r_cp] && eng.eng_done[r_cp] && !r_eng_start[r_cp]
                       && (!r_out_valid || pix.out_ready);
    assign w_last_hs = r_out_valid && pix.out_ready
                       && (r_out.x == X_W'(SCREEN_W - 1)) && (r_out.y == Y_W'(SCREEN_H - 1));

    always_ff @(posedge sysclk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_issue && w_last_pixel) ? FLUSH : RUN;
            RUN:     if (w_issue && w_last_pixel) w_state_nxt = FLUSH;
            FLUSH:   if (w_last_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_ip         <= '0;
            r_cp         <= '0;
            r_eng_busy   <= '0;
            r_eng_start  <= '0;
            r_eng_eol    <= '0;
            r_eng_x      <= '0;
            r_eng_y      <= '0;
            r_eng_re     <= '0;
            r_eng_im     <= '0;
            r_max_iter   <= '0;
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
            r_out_eol    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_eng_start  <= '0;
            r_frame_done <= (r_state == FLUSH) && w_last_hs;
            if (w_accept) r_max_iter <= cfg_max_iter;

            if (w_issue) begin
                r_eng_start[r_ip] <= 1'b1;
                r_eng_busy[r_ip]  <= 1'b1;
                r_eng_x[r_ip]     <= w_x;
                r_eng_y[r_ip]     <= w_y;
                r_eng_re[r_ip]    <= w_re;
                r_eng_im[r_ip]    <= w_im;
                r_eng_eol[r_ip]   <= w_eol;
                r_ip <= (r_ip == PTR_W'(N_ENG - 1)) ? '0 : r_ip + 1'b1;
            end

            // Issue needs busy clear and collect needs busy set, so r_ip != r_cp here.
            if (w_collect) begin
                r_eng_busy[r_cp] <= 1'b0;
                r_out.x          <= r_eng_x[r_cp];
                r_out.y          <= r_eng_y[r_cp];
                r_out.depth      <= eng.eng_depth[r_cp];
                r_out_sof        <= (r_eng_x[r_cp] == '0) && (r_eng_y[r_cp] == '0);
                r_out_eol        <= r_eng_eol[r_cp];
                r_out_valid      <= 1'b1;
                r_cp <= (r_cp == PTR_W'(N_ENG - 1)) ? '0 : r_cp + 1'b1;
            end else if (pix.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MANDEL_FRAME_STATS_EN
    logic [31:0] r_stat_cycles;
    logic [31:0] r_stat_iter_sum;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_stat_cycles   <= '0;
            r_stat_iter_sum <= '0;
        end else if (w_accept) begin
            r_stat_cycles   <= '0;
            r_stat_iter_sum <= '0;
        end else begin
            if (busy)      r_stat_cycles   <= r_stat_cycles + 32'd1;
            if (w_collect) r_stat_iter_sum <= r_stat_iter_sum + 32'(eng.eng_depth[r_cp]);
        end
    end

    assign stat_cycles   = r_stat_cycles;
    assign stat_iter_sum = r_stat_iter_sum;
`endif

    assign busy             = (r_state != IDLE);
    assign frame_done       = r_frame_done;
    assign eng.eng_start    = r_eng_start;
    assign eng.eng_x        = r_eng_x;
    assign eng.eng_y        = r_eng_y;
    assign eng.eng_re_c     = r_eng_re;
    assign eng.eng_im_c     = r_eng_im;
    assign eng.eng_max_iter = r_max_iter;
    assign pix.out_valid    = r_out_valid;
    assign pix.out_depth    = r_out.depth;
    assign pix.out_x        = r_out.x;
    assign pix.out_y        = r_out.y;
    assign pix.out_sof      = r_out_sof;
    assign pix.out_eol      = r_out_eol;

endmodule
`default_nettype wire

// File: tb/tb_mandel_pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_mandel_pixel_dispatcher
// Description : Randomised bench for mandel_pixel_dispatcher on an 8x4 screen
//               with four behavioural engines of random latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mandel_pixel_dispatcher;
    localparam int N_ENG = 4;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int NPIX  = W * H;
    localparam int BOUND = 20000;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [31:0] cfg_re_left = '0;
    logic [31:0] cfg_im_top = '0;
    logic [31:0] cfg_step = '0;
    logic [9:0]  cfg_max_iter = '0;
    logic        busy;
    logic        frame_done;
    logic        out_ready = 1'b1;
`ifdef MANDEL_FRAME_STATS_EN
    logic [31:0] stat_cycles;
    logic [31:0] stat_iter_sum;
`endif

    mandel_eng_if #(.N_ENG(N_ENG), .WORD_LENGTH(32)) eng();
    mandel_pix_if pix();

    mandel_pixel_dispatcher #(
        .N_ENG(N_ENG), .WORD_LENGTH(32), .SCREEN_W(W), .SCREEN_H(H)
    ) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .frame_start   (frame_start),
        .cfg_re_left   (cfg_re_left),
        .cfg_im_top    (cfg_im_top),
        .cfg_step      (cfg_step),
        .cfg_max_iter  (cfg_max_iter),
        .busy          (busy),
        .frame_done    (frame_done),
`ifdef MANDEL_FRAME_STATS_EN
        .stat_cycles   (stat_cycles),
        .stat_iter_sum (stat_iter_sum),
`endif
        .eng           (eng),
        .pix           (pix)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_re, m_im, m_step;
    logic [9:0]  m_max_iter;
    bit          depth_five = 1'b0;
    int          lat_mode   = 0;
    bit          rnd_ready  = 1'b0;

    function automatic logic [9:0] hash(input logic [9:0] x, input logic [8:0] y,
                                        input logic [31:0] re, input logic [31:0] im);
        return re[31:22] ^ re[21:12] ^ im[31:22] ^ im[21:12] ^ x ^ {y, 1'b0};
    endfunction

    function automatic logic [31:0] ref_re(input int n);
        return m_re + 32'(n % W) * m_step;
    endfunction

    function automatic logic [31:0] ref_im(input int n);
        return m_im - 32'(n / W) * m_step;
    endfunction

    function automatic logic [9:0] ref_depth(input int n);
        if (depth_five) return 10'd5;
        return hash(10'(n % W), 9'(n / W), ref_re(n), ref_im(n));
    endfunction

    // ---------------- behavioural engines ----------------
    logic [N_ENG-1:0]       e_done = '0;
    logic [N_ENG-1:0][9:0]  e_depth = '0;
    int                     e_cnt [N_ENG];

    function automatic int pick_lat(input int e);
        if (lat_mode == 1 && e == 0) return 40;
        if (lat_mode == 1 && e == 1) return 3;
        return int'($urandom_range(3, 40));
    endfunction

    assign eng.eng_done  = e_done;
    assign eng.eng_depth = e_depth;
    assign pix.out_ready = out_ready;

    always @(posedge sysclk) begin
        for (int e = 0; e < N_ENG; e++) begin
            if (reset) begin
                e_done[e] <= 1'b0;
                e_cnt[e]  <= 0;
            end else if (eng.eng_start[e]) begin
                e_done[e] <= 1'b0;
                e_cnt[e]  <= pick_lat(e);
            end else if (e_cnt[e] == 1) begin
                e_done[e]  <= 1'b1;
                e_depth[e] <= depth_five ? 10'd5 :
                              hash(eng.eng_x[e], eng.eng_y[e], eng.eng_re_c[e], eng.eng_im_c[e]);
                e_cnt[e]   <= 0;
            end else if (e_cnt[e] > 1) begin
                e_cnt[e] <= e_cnt[e] - 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int          n_iss, n_out, n_load, n_done, busy_cnt;
    int          starts [N_ENG];
    int          colls  [N_ENG];
    bit          pv, pr, last_hs_prev;
    logic [30:0] held;

    always @(negedge sysclk) begin
        logic [30:0] cur;
        bit          hs;
        cur = {pix.out_x, pix.out_y, pix.out_depth, pix.out_sof, pix.out_eol};
        if (reset) begin
            n_iss = 0; n_out = 0; n_load = 0; n_done = 0; busy_cnt = 0;
            pv = 1'b0; pr = 1'b0; last_hs_prev = 1'b0;
            for (int e = 0; e < N_ENG; e++) begin starts[e] = 0; colls[e] = 0; end
        end else begin
            for (int e = 0; e < N_ENG; e++) begin
                if (eng.eng_start[e]) begin
                    check_eq("restart_before_collect", 64'(starts[e] - colls[e]), 64'd0);
                    check_eq("start_engine", 64'(e), 64'(n_iss % N_ENG));
                    check_eq("start_xy", {eng.eng_x[e], eng.eng_y[e]},
                             {10'(n_iss % W), 9'(n_iss / W)});
                    check_eq("start_re_c", eng.eng_re_c[e], ref_re(n_iss));
                    check_eq("start_im_c", eng.eng_im_c[e], ref_im(n_iss));
                    check_eq("start_max_iter", eng.eng_max_iter, m_max_iter);
                    if (m_re == 32'hE000_0000 && m_im == 32'h1000_0000 && m_step == 32'h0800_0000
                        && eng.eng_x[e] == 10'd3 && eng.eng_y[e] == 9'd2) begin
                        check_eq("pix32_re_c", eng.eng_re_c[e], 32'hF800_0000);
                        check_eq("pix32_im_c", eng.eng_im_c[e], 32'h0000_0000);
                    end
                    starts[e]++;
                    n_iss++;
                end
            end
            if (pix.out_valid && (!pv || pr)) begin
                colls[n_load % N_ENG]++;
                n_load++;
            end
            if (pv && !pr) begin
                check_eq("stall_valid", pix.out_valid, 1'b1);
                check_eq("stall_hold", cur, held);
            end
            hs = pix.out_valid && pix.out_ready;
            if (hs) begin
                check_eq("out_xy", {pix.out_x, pix.out_y}, {10'(n_out % W), 9'(n_out / W)});
                check_eq("out_depth", pix.out_depth, ref_depth(n_out));
                check_eq("out_sof", pix.out_sof, n_out == 0);
                check_eq("out_eol", pix.out_eol, (n_out % W) == W - 1);
                n_out++;
            end
            if (frame_done) begin
                check_eq("frame_done_timing", last_hs_prev, 1'b1);
                n_done++;
            end
            last_hs_prev = hs && (n_out == NPIX);
            if (busy) busy_cnt++;
            if (frame_start && !busy) begin
                m_re = cfg_re_left; m_im = cfg_im_top; m_step = cfg_step; m_max_iter = cfg_max_iter;
                n_iss = 0; n_out = 0; n_load = 0; n_done = 0; busy_cnt = 0;
                for (int e = 0; e < N_ENG; e++) begin starts[e] = 0; colls[e] = 0; end
            end
            pv = pix.out_valid;
            pr = pix.out_ready;
            held = cur;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge sysclk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_frame(input logic [31:0] re, input logic [31:0] im,
                               input logic [31:0] st, input logic [9:0] mi);
        cfg_re_left = re; cfg_im_top = im; cfg_step = st; cfg_max_iter = mi;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check_eq("first_start_latency", eng.eng_start, 4'b0001);
        check_eq("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (n_out < n && k < BOUND) begin step(); k++; end
        check_eq("wait_out_timeout", k < BOUND, 1'b1);
    endtask

    task automatic wait_frame();
        int k = 0;
        while (!(n_out == NPIX && n_done >= 1) && k < BOUND) begin step(); k++; end
        check_eq("frame_timeout", k < BOUND, 1'b1);
        repeat (3) step();
        check_eq("frame_pixels", 64'(n_out), 64'(NPIX));
        check_eq("frame_issues", 64'(n_iss), 64'(NPIX));
        check_eq("frame_done_count", 64'(n_done), 64'd1);
        check_eq("idle_after_frame", busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_out_valid", pix.out_valid, 1'b0);
        check_eq("rst_eng_start", eng.eng_start, 4'b0000);
        check_eq("rst_max_iter", eng.eng_max_iter, 10'd0);
        check_eq("rst_out_fields", {pix.out_x, pix.out_y, pix.out_depth, pix.out_sof, pix.out_eol}, 31'd0);
        reset = 1'b0;
        step();

        // Known c-plane window, always-ready sink.
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd100);
        wait_frame();

        // Engine 0 slow, engine 1 fast, random back-pressure.
        lat_mode = 1; rnd_ready = 1'b1;
        start_frame($urandom, $urandom, $urandom, 10'($urandom));
        wait_frame();
        lat_mode = 0;

        // A second frame_start mid-frame must be ignored.
        start_frame($urandom, $urandom, $urandom, 10'($urandom));
        wait_out(10);
        cfg_re_left = $urandom; cfg_im_top = $urandom; cfg_step = $urandom; cfg_max_iter = 10'($urandom);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_frame();

        // Reset mid-frame abandons it.
        start_frame($urandom, $urandom, $urandom, 10'($urandom));
        wait_out(10);
        reset = 1'b1;
        step();
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_out_valid", pix.out_valid, 1'b0);
        reset = 1'b0;
        step();

`ifdef MANDEL_FRAME_STATS_EN
        depth_five = 1'b1;
`endif
        start_frame($urandom, $urandom, $urandom, 10'($urandom));
        wait_frame();
`ifdef MANDEL_FRAME_STATS_EN
        check_eq("stat_iter_sum", stat_iter_sum, 32'd160);
        check_eq("stat_cycles", stat_cycles, 32'(busy_cnt));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
